// File: rtl/avg_pkg.sv
// Shared types and helpers for the median/average sample filter.
package avg_pkg;

    typedef enum logic {
        AVG_BLOCK = 1'b0,
        AVG_SLIDE = 1'b1
    } avg_mode_e;

    function automatic int depth_of(input int depth_log2);
        return 1 << depth_log2;
    endfunction

endpackage

// File: rtl/sample_ring.sv
// Register ring holding the averaging window; zero-latency read of the oldest entry.
module sample_ring
    import avg_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] oldest
);
    localparam int DEPTH = depth_of(DEPTH_LOG2);

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] ptr;
    logic [DEPTH_LOG2-1:0] wptr;

    // A clear coinciding with a write starts the new window at slot 0.
    assign wptr   = clr ? '0 : ptr;
    assign oldest = mem[ptr];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wptr] <= din;
            ptr       <= wptr + DEPTH_LOG2'(1);
        end else begin
            ptr <= wptr;
        end
    end

endmodule

// File: rtl/median_avg_filter.sv
// Strobe synchroniser, optional median-of-3, windowed sum and average output.
module median_avg_filter
    import avg_pkg::*;
#(
    parameter int        DATA_W     = 16,
    parameter int        DEPTH_LOG2 = 3,
    parameter bit        MED_EN     = 1'b1,
    parameter avg_mode_e AVG_MODE   = AVG_BLOCK
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic [DATA_W-1:0]   data_i,
    input  logic                data_av_ai,
    input  logic                flush_i,
    output logic [DATA_W-1:0]   avg_o,
    output logic                avg_valid_o,
    output logic [DEPTH_LOG2:0] count_o,
    output logic                full_o
);
    localparam int                  DEPTH     = depth_of(DEPTH_LOG2);
    localparam int                  SUM_W     = DATA_W + DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    function automatic logic [DATA_W-1:0] median3(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input logic [DATA_W-1:0] c);
        logic [DATA_W-1:0] lo;
        logic [DATA_W-1:0] hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        if (c < lo)      return lo;
        else if (c > hi) return hi;
        else             return c;
    endfunction

    logic av_ff1, av_ff2, av_ff3, strobe;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            av_ff1 <= 1'b0;
            av_ff2 <= 1'b0;
            av_ff3 <= 1'b0;
        end else begin
            av_ff1 <= data_av_ai;
            av_ff2 <= av_ff1;
            av_ff3 <= av_ff2;
        end
    end

    assign strobe = av_ff2 & ~av_ff3;

    logic [DATA_W-1:0] hist0, hist1, hist2;
    logic [1:0]        prime_cnt;
    logic              hist_valid;

    // With the median enabled, the first two strobes only fill the history.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            hist0      <= '0;
            hist1      <= '0;
            hist2      <= '0;
            prime_cnt  <= '0;
            hist_valid <= 1'b0;
        end else if (flush_i) begin
            hist0      <= '0;
            hist1      <= '0;
            hist2      <= '0;
            prime_cnt  <= '0;
            hist_valid <= 1'b0;
        end else begin
            hist_valid <= 1'b0;
            if (strobe) begin
                hist0 <= data_i;
                hist1 <= hist0;
                hist2 <= hist1;
                if (!MED_EN || prime_cnt == 2'd2) begin
                    hist_valid <= 1'b1;
                end else begin
                    prime_cnt <= prime_cnt + 2'd1;
                end
            end
        end
    end

    logic [DATA_W-1:0] med_q;
    logic              med_valid;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            med_q     <= '0;
            med_valid <= 1'b0;
        end else if (flush_i) begin
            med_valid <= 1'b0;
        end else begin
            med_valid <= hist_valid;
            if (hist_valid) begin
                med_q <= MED_EN ? median3(hist0, hist1, hist2) : hist0;
            end
        end
    end

    logic [SUM_W-1:0]      sum_q, sum_nxt;
    logic [DEPTH_LOG2:0]   count_q, count_nxt;
    logic                  ring_clr, ring_wr;
    logic                  win_done_q, win_done_nxt;
    logic [DATA_W-1:0]     oldest;

    sample_ring #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ring (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr    (ring_clr),
        .wr_en  (ring_wr),
        .din    (med_q),
        .oldest (oldest)
    );

    // In block mode a full window is emptied the cycle after it completes.
    always_comb begin
        sum_nxt      = sum_q;
        count_nxt    = count_q;
        ring_clr     = 1'b0;
        ring_wr      = 1'b0;
        win_done_nxt = 1'b0;
        if (flush_i) begin
            sum_nxt   = '0;
            count_nxt = '0;
            ring_clr  = 1'b1;
        end else begin
            if (AVG_MODE == AVG_BLOCK && count_q == DEPTH_CNT) begin
                sum_nxt   = '0;
                count_nxt = '0;
                ring_clr  = 1'b1;
            end
            if (med_valid) begin
                ring_wr = 1'b1;
                if (count_nxt == DEPTH_CNT) begin
                    sum_nxt = sum_q + SUM_W'(med_q) - SUM_W'(oldest);
                end else begin
                    sum_nxt   = sum_nxt + SUM_W'(med_q);
                    count_nxt = count_nxt + (DEPTH_LOG2 + 1)'(1);
                end
                win_done_nxt = (count_nxt == DEPTH_CNT);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sum_q      <= '0;
            count_q    <= '0;
            win_done_q <= 1'b0;
        end else begin
            sum_q      <= sum_nxt;
            count_q    <= count_nxt;
            win_done_q <= win_done_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            avg_o       <= '0;
            avg_valid_o <= 1'b0;
        end else begin
            avg_valid_o <= win_done_q & ~flush_i;
            if (win_done_q && !flush_i) begin
                avg_o <= sum_q[SUM_W-1:DEPTH_LOG2];
            end
        end
    end

    assign count_o = count_q;
    assign full_o  = (count_q == DEPTH_CNT);

endmodule

// File: doc/median_avg_filter.md
# median_avg_filter

Parametrised successor to the sample-acquisition chain: synchronises an asynchronous data-available strobe, optionally median-of-3 filters the incoming unsigned samples, keeps a DEPTH-entry window in an internal ring and outputs the window average. It supports two modes. Block mode emits one average per DEPTH samples. Sliding mode emits one average per sample once the window is full. It replaces the fixed sync/median/write-FSM/BRAM/read-FSM chain with one pipelined block of deterministic latency.

## Interface
- DATA_W, 16, sample and average width (unsigned)
- DEPTH_LOG2, 3, window depth = 2**DEPTH_LOG2 (1..8)
- MED_EN, 1, 1 = median-of-3 stage active, 0 = stage passes raw samples (same latency)
- AVG_MODE, AVG_BLOCK, avg_mode_e: AVG_BLOCK or AVG_SLIDE

Ports:
- clk_i  in  1  single clock
- rstn_i  in  1  asynchronous, active-low reset
- data_i  in  DATA_W  sample, stable while strobe is being synchronised
- data_av_ai  in  1  asynchronous sample strobe, rising edge = new sample
- flush_i  in  1  synchronous window clear
- avg_o  out  DATA_W  last computed average
- avg_valid_o  out  1  one-cycle pulse, avg_o updated
- count_o  out  DEPTH_LOG2+1  samples currently in window
- full_o  out  1  count_o == DEPTH

## Operation
- Sync: 2 flops plus an edge-detect flop on data_av_ai. The internal strobe is ff2 & ~ff3, one cycle long.
- Median: a 3-entry history is shifted on each strobe.
  - MED_EN=1: the first two strobes after reset or flush only prime the history and produce no filtered sample. Each later strobe yields median(h0,h1,h2).
  - MED_EN=0: each strobe yields the raw sample.
- Window: a filtered sample is written at the ring write pointer, and the pointer wraps modulo DEPTH.
  - sum width is DATA_W+DEPTH_LOG2, so it cannot overflow.
  - When not full: sum += new, and count increments.
  - When full (sliding mode only): sum += new − evicted oldest entry.
- Average: avg_o = sum >> DEPTH_LOG2, truncated (floor). No rounding.
- AVG_BLOCK:
  - When count reaches DEPTH, avg_valid_o pulses.
  - On the next cycle, sum, count and the pointer clear.
  - full_o is high for exactly that one cycle.
- AVG_SLIDE:
  - The first avg_valid_o comes on the DEPTH-th filtered sample.
  - After that, one pulse per filtered sample.
  - count saturates at DEPTH, and full_o stays high.
- flush_i clears the median history, sum, count, pointer and all in-flight pipeline valids. avg_o holds its last value.
- flush_i coincident with a strobe or an in-flight sample: flush wins and the sample is dropped.
- Reset values: avg_o=0, avg_valid_o=0, count_o=0, full_o=0. The sync flops, history, ring contents, sum and pointer are also 0.
- Reset mid-operation clears everything asynchronously. No partial window survives.

## Timing
- Edge numbering starts at E1, the first clk_i edge that samples data_av_ai high.
  - E1, E2: sync flops.
  - E3: data_i captured into history. The strobe is high between E2 and E3.
  - E4: median register and med_valid.
  - E5: ring write, sum and count update.
  - E6: avg_o and avg_valid_o registered.
- Total latency: 6 edges, both MED_EN settings.
- data_i must be stable from 1 cycle before E1 through E3.
- data_av_ai must be high for ≥2 cycles and low for ≥2 cycles. The pipeline accepts one sample per cycle, so back-to-back strobes never stall.
- No backpressure. avg_valid_o is never held.

## Structure
- Package avg_pkg holds:
  - typedef enum avg_mode_e {AVG_BLOCK, AVG_SLIDE}
  - localparam DEPTH = 2**DEPTH_LOG2 (helper function)
- Sub-module sample_ring: DEPTH×DATA_W register ring with write pointer and wrap.
  - Inputs: wr_en, din, clr.
  - Output: oldest entry for eviction.
  - Registers, not BRAM, so read latency is zero.
- Top contains the sync, the median stage, the sum/count control and the output register.

## Test plan
Parameters: DATA_W=16, DEPTH_LOG2=3.
- MED_EN=0, AVG_BLOCK, samples 1..8 → single avg_valid_o at E6 of sample 8, avg_o=4 (36/8 floored). No earlier pulse. count_o returns to 0.
- MED_EN=1, AVG_BLOCK, samples 10,10,1000,10,10,10,10,10,10,10 → the 1000 spike never reaches the window. After 2 priming + 8 filtered samples, avg_o=10.
- MED_EN=0, AVG_SLIDE, 8×100 then 900 → avg_o=100 on sample 8, then avg_o=200 on sample 9. full_o stays 1.
- MED_EN=0, 8×0xFFFF → avg_o=0xFFFF with no sum overflow.
- flush_i asserted in the strobe cycle of sample 5 → sample dropped, count_o=0. Then 8×7 → avg_o=7.
- rstn_i low with count_o=5 → all outputs 0 immediately. After release, 8×3 → avg_o=3.
